// File: rtl/dm_responder.sv
// Data-memory responder: word RAM plus a memory-mapped I/O page (LEDs, synchronized
// switches, down-counting timer with reload and interrupt). Loads are combinational.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] IO_BASE     = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        MemWrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [5:0] OFF_LED     = 6'h00;
  localparam logic [5:0] OFF_SW      = 6'h01;
  localparam logic [5:0] OFF_TCTRL   = 6'h02;
  localparam logic [5:0] OFF_TPRESET = 6'h03;
  localparam logic [5:0] OFF_TCOUNT  = 6'h04;

  logic [31:0] mem [DEPTH_WORDS];

  logic [15:0] led_q, led_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        done_q, done_d;
  logic        ie_q, ie_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic          io_hit;
  logic [5:0]    io_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          wr_led, wr_tctrl, wr_tpreset;
  logic [31:0]   io_rdata;
  logic          unused_addr_lsbs;

  // Accesses are word-only; the byte lane bits carry no information.
  assign unused_addr_lsbs = ^addr[1:0];

  assign io_hit     = (addr[31:8] == IO_BASE[31:8]);
  assign io_off     = addr[7:2];
  assign ram_idx    = addr[AW+1:2];
  assign ram_we     = MemWrite & ~io_hit;
  assign wr_led     = MemWrite & io_hit & (io_off == OFF_LED);
  assign wr_tctrl   = MemWrite & io_hit & (io_off == OFF_TCTRL);
  assign wr_tpreset = MemWrite & io_hit & (io_off == OFF_TPRESET);

  // Word RAM: written at the edge, read asynchronously (pre-write data in a write cycle).
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= writedata;
    end
  end

  // I/O page read mux.
  always_comb begin
    io_rdata = 32'd0;
    case (io_off)
      OFF_LED:     io_rdata = {16'd0, led_q};
      OFF_SW:      io_rdata = {16'd0, sw_sync_q};
      OFF_TCTRL:   io_rdata = {28'd0, ie_q, done_q, auto_q, en_q};
      OFF_TPRESET: io_rdata = preset_q;
      OFF_TCOUNT:  io_rdata = count_q;
      default:     io_rdata = 32'd0;
    endcase
  end

  assign readdata = io_hit ? io_rdata : mem[ram_idx];

  // Register writes and timer tick; the tick uses pre-write EN/AUTO and a DONE set
  // beats a same-cycle write-1-to-clear, while a TPRESET write overrides the tick.
  always_comb begin
    led_d    = led_q;
    en_d     = en_q;
    auto_d   = auto_q;
    done_d   = done_q;
    ie_d     = ie_q;
    preset_d = preset_q;
    count_d  = count_q;

    if (wr_led) begin
      led_d = writedata[15:0];
    end

    if (wr_tctrl) begin
      en_d   = writedata[0];
      auto_d = writedata[1];
      ie_d   = writedata[3];
      if (writedata[2]) begin
        done_d = 1'b0;
      end
    end

    if (wr_tpreset) begin
      preset_d = writedata;
      count_d  = writedata;
      done_d   = 1'b0;
    end else if (en_q) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        done_d  = 1'b1;
        count_d = auto_q ? preset_q : 32'd0;
      end
    end

    irq_d = done_d & ie_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= 16'd0;
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      done_q    <= 1'b0;
      ie_q      <= 1'b0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      en_q      <= en_d;
      auto_q    <= auto_d;
      done_q    <= done_d;
      ie_q      <= ie_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
    end
  end

  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed scenarios then randomized accesses,
// checked against an event-level model of the memory map and timer.
module tb_dm_responder;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam logic [31:0] IO_BASE     = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] sw = 16'd0;
  logic [15:0] led;
  logic        irq;

  dm_responder #(.DEPTH_WORDS(DEPTH_WORDS), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .MemWrite(MemWrite), .writedata(writedata),
    .readdata(readdata), .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] id;
    logic        chk_rd;
    logic [31:0] rd;
    logic [15:0] led;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   id_cnt   = 0;

  // Reference model state
  logic [31:0] m_ram [int unsigned];
  logic [15:0] m_led, m_sw1, m_sw2;
  logic        m_en, m_auto, m_done, m_ie, m_irq;
  logic [31:0] m_preset, m_count;

  function automatic void model_reset();
    m_led = 0; m_sw1 = 0; m_sw2 = 0;
    m_en = 0; m_auto = 0; m_done = 0; m_ie = 0; m_irq = 0;
    m_preset = 0; m_count = 0;
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return a[31:8] == IO_BASE[31:8];
  endfunction

  // {check-valid, data}
  function automatic logic [32:0] model_read(input logic [31:0] a);
    int unsigned w;
    logic [7:0]  off;
    off = {a[7:2], 2'b00};
    if (is_io(a)) begin
      case (off)
        8'h00:   return {1'b1, 16'd0, m_led};
        8'h04:   return {1'b1, 16'd0, m_sw2};
        8'h08:   return {1'b1, 28'd0, m_ie, m_done, m_auto, m_en};
        8'h0C:   return {1'b1, m_preset};
        8'h10:   return {1'b1, m_count};
        default: return {1'b1, 32'd0};
      endcase
    end
    w = (a / 4) % DEPTH_WORDS;
    if (m_ram.exists(w)) return {1'b1, m_ram[w]};
    return {1'b0, 32'd0};
  endfunction

  function automatic void model_edge(input logic [31:0] a, input logic we,
                                     input logic [31:0] wd, input logic [15:0] s);
    logic       en0, auto0;
    logic [7:0] off;
    off   = {a[7:2], 2'b00};
    en0   = m_en;
    auto0 = m_auto;
    m_sw2 = m_sw1;
    m_sw1 = s;
    if (we && !is_io(a)) m_ram[(a / 4) % DEPTH_WORDS] = wd;
    if (we && is_io(a) && off == 8'h00) m_led = wd[15:0];
    if (we && is_io(a) && off == 8'h08) begin
      m_en = wd[0]; m_auto = wd[1]; m_ie = wd[3];
      if (wd[2]) m_done = 0;
    end
    if (we && is_io(a) && off == 8'h0C) begin
      m_preset = wd; m_count = wd; m_done = 0;
    end else if (en0 && m_count != 0) begin
      if (m_count == 1) begin
        m_done  = 1;
        m_count = auto0 ? m_preset : 32'd0;
      end else begin
        m_count = m_count - 1;
      end
    end
    m_irq = m_done & m_ie;
  endfunction

  function automatic void check(input string what, input int id,
                                input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s id=%0d actual=%h required=%h", what, id, act, req);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] a);
    exp_t        e;
    logic [32:0] r;
    r        = model_read(a);
    e.id     = 16'(id_cnt);
    e.chk_rd = r[32];
    e.rd     = r[31:0];
    e.led    = m_led;
    e.irq    = m_irq;
    exp_q.push_back(e);
    id_cnt++;
  endfunction

  // Monitor: compares the DUT against the oldest pending expectation, mid-cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk_rd) check("readdata", int'(mon_e.id), readdata, mon_e.rd);
      check("led", int'(mon_e.id), {16'd0, led}, {16'd0, mon_e.led});
      check("irq", int'(mon_e.id), {31'd0, irq}, {31'd0, mon_e.irq});
    end
  end

  task automatic cycle(input logic [31:0] a, input logic we, input logic [31:0] wd);
    addr = a; MemWrite = we; writedata = wd;
    push_exp(a);
    @(posedge clk);
    if (rst) model_edge(a, we, wd, sw);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(a, 1'b1, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 1'b0, 32'd0);
  endtask

  // Asynchronous reset between edges; the expectation is checked before any edge.
  task automatic do_reset();
    addr = IO_BASE + 32'h10; MemWrite = 1'b0; writedata = 32'd0;
    rst = 1'b0;
    model_reset();
    push_exp(addr);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    rd(IO_BASE + 32'h08);
    rd(IO_BASE + 32'h10);
    rd(IO_BASE + 32'h00);

    // RAM write/read, pre-write read data, aliasing
    wr(32'h0000_0010, 32'h1111_1111);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010);
    rd(32'h0000_0010 + 4 * DEPTH_WORDS);
    rd(32'h0000_0013);
    for (int i = 0; i < 8; i++) wr(32'h0000_0100 + 32'(i * 4), $urandom);

    // LED and switch synchronizer latency
    wr(IO_BASE + 32'h00, 32'hFFFF_1234);
    rd(IO_BASE + 32'h00);
    sw = 16'hA5A5;
    rd(IO_BASE + 32'h04);
    rd(IO_BASE + 32'h04);
    rd(IO_BASE + 32'h04);
    wr(IO_BASE + 32'h04, 32'h0000_FFFF);
    rd(IO_BASE + 32'h04);

    // One-shot countdown
    wr(IO_BASE + 32'h0C, 32'd3);
    wr(IO_BASE + 32'h08, 32'h9);
    repeat (6) rd(IO_BASE + 32'h10);
    rd(IO_BASE + 32'h08);

    // Auto-reload, and DONE set beating a same-cycle clear
    wr(IO_BASE + 32'h08, 32'h4);
    wr(IO_BASE + 32'h0C, 32'd2);
    wr(IO_BASE + 32'h08, 32'hB);
    repeat (6) rd(IO_BASE + 32'h10);
    for (int k = 0; k < 10 && m_count != 2; k++) rd(IO_BASE + 32'h10);
    wr(IO_BASE + 32'h08, 32'hF);
    wr(IO_BASE + 32'h08, 32'h7);
    rd(IO_BASE + 32'h08);
    rd(IO_BASE + 32'h10);

    // TPRESET write mid-count
    wr(IO_BASE + 32'h0C, 32'd10);
    wr(IO_BASE + 32'h08, 32'h9);
    rd(IO_BASE + 32'h10);
    rd(IO_BASE + 32'h10);
    wr(IO_BASE + 32'h0C, 32'd7);
    rd(IO_BASE + 32'h10);
    rd(IO_BASE + 32'h08);

    // Reset mid-count with irq asserted; RAM must survive
    wr(IO_BASE + 32'h0C, 32'd4);
    wr(IO_BASE + 32'h08, 32'hB);
    for (int k = 0; k < 20 && !(m_irq && m_count > 1); k++) rd(IO_BASE + 32'h10);
    do_reset();
    rd(32'h0000_0010);
    rd(IO_BASE + 32'h10);
    rd(IO_BASE + 32'h10);
    rd(IO_BASE + 32'h00);

    // Randomized mix
    for (int n = 0; n < 500; n++) begin
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      if (op <= 2) begin
        a = $urandom;
        a[11:2] = 10'h040 + 10'($urandom_range(0, 7));
        if (is_io(a)) a[31] = ~a[31];
        cycle(a, op == 0, $urandom);
      end else if (op <= 6) begin
        a = IO_BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        rd(a);
      end else if (op == 7) begin
        wr(IO_BASE + 32'h08, {28'($urandom), 4'($urandom)} | 32'h1);
      end else if (op == 8) begin
        wr(IO_BASE + 32'h0C, 32'($urandom_range(0, 5)));
      end else begin
        a = IO_BASE + 32'($urandom_range(0, 7) * 4);
        wr(a, $urandom);
      end
    end

    MemWrite = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
